// File: rtl/apb_rr_master.sv
// apb_rr_master
//   Round-robin APB master. It shares one zero-wait-state APB slave between
//   NUM_REQ local requesters. Each accepted command runs through the APB
//   SETUP and ACCESS phases. The result is returned to the winning requester
//   as a one-cycle response pulse.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for req_valid; grants the round-robin winner
//   SETUP  | PSEL=1, PENABLE=0 with the latched command on PADDR/PWDATA
//   ACCESS | PSEL=1, PENABLE=1; the slave acts/registers PRDATA on this edge
//   DONE   | rsp_valid pulse with rsp_id and rsp_rdata
//
// Ports
//   PCLK, PRESET             clock, synchronous active-high reset
//   req_valid/write          per-requester command valid and direction
//   req_addr/req_wdata       packed per-requester address / write data
//   req_ready                one-hot accept pulse (IDLE only)
//   rsp_valid/id/rdata       completion pulse, requester index, read data
//   busy                     high whenever the FSM is not in IDLE
//   PSEL..PWDATA, PRDATA     APB master interface
module apb_rr_master #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 8,
    parameter int DW      = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [AW-1:0]         PADDR,
    output logic [DW-1:0]         PWDATA,
    input  logic [DW-1:0]         PRDATA
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_cmd_id;
    logic            r_pwrite;
    logic [AW-1:0]   r_paddr;
    logic [DW-1:0]   r_pwdata;

    logic [IDW-1:0]  w_winner;
    logic [IDW-1:0]  w_ptr_nxt;
    logic            w_found;
    logic            w_accept;
    int              w_idx;

    // Scan from rr_ptr upward, wrapping at NUM_REQ (not at 2**IDW, so
    // non-power-of-two requester counts rotate correctly).
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(w_idx);
            end
        end
    end

    assign w_ptr_nxt = (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + IDW'(1);
    assign w_accept  = (r_state == S_IDLE) && w_found && !PRESET;
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_winner) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_cmd_id <= '0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Command registers hold their value between transfers.
            if (w_accept) begin
                r_rr_ptr <= w_ptr_nxt;
                r_cmd_id <= w_winner;
                r_pwrite <= req_write[w_winner];
                r_paddr  <= req_addr[int'(w_winner)*AW +: AW];
                r_pwdata <= req_wdata[int'(w_winner)*DW +: DW];
            end
        end
    end

    assign PSEL      = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign PENABLE   = (r_state == S_ACCESS);
    assign busy      = (r_state != S_IDLE);
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

    // The slave registered PRDATA on the ACCESS edge, so it is valid in DONE.
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_id    = rsp_valid ? r_cmd_id : '0;
    assign rsp_rdata = (rsp_valid && !r_pwrite) ? PRDATA : '0;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master
//   Directed bench for apb_rr_master (NUM_REQ=2) with a behavioural APB
//   slave. Expected responses are queued as commands are granted; a monitor
//   pops and compares on every rsp_valid pulse.
module tb_apb_rr_master;

    localparam int NUM_REQ = 2;
    localparam int AW      = 8;
    localparam int DW      = 32;

    logic                  PCLK;
    logic                  PRESET;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [0:0]            rsp_id;
    logic [DW-1:0]         rsp_rdata;
    logic                  busy;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [AW-1:0]         PADDR;
    logic [DW-1:0]         PWDATA;
    logic [DW-1:0]         PRDATA;

    apb_rr_master #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // APB slave: acts on the ACCESS edge; unwritten locations read as 0.
    logic [DW-1:0] mem [256];
    logic [255:0]  written;
    always @(posedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (PWRITE) begin
                mem[PADDR]     <= PWDATA;
                written[PADDR] <= 1'b1;
            end else begin
                PRDATA <= (written[PADDR] === 1'b1) ? mem[PADDR] : '0;
            end
        end
    end

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor
    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d data %h expected no response", rsp_id, rsp_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    task automatic drive_cmd(input int id, input logic wr, input logic [7:0] addr, input logic [31:0] wd);
        req_valid[id]          = 1'b1;
        req_write[id]          = wr;
        req_addr[id*AW +: AW]  = addr;
        req_wdata[id*DW +: DW] = wd;
    endtask

    // Waits (bounded) for req_ready[id] at a negedge.
    task automatic wait_grant(input int id, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (req_ready[id] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: requester %0d got no req_ready within 20 cycles, required a grant", id);
        end
    endtask

    // Single transfer with phase-by-phase latency checks.
    task automatic xfer(input int id, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
        bit got;
        exp_t e;
        @(posedge PCLK); #1;
        drive_cmd(id, wr, addr, wd);
        wait_grant(id, got);
        if (got) begin
            chk("ready_onehot", 32'(req_ready), 32'(1) << id);
            e.id = id;
            e.rdata = exp_rd;
            exp_q.push_back(e);
            @(posedge PCLK); #1;
            req_valid[id] = 1'b0;
            @(negedge PCLK);
            chk("T1_psel", 32'(PSEL), 32'd1);
            chk("T1_penable", 32'(PENABLE), 32'd0);
            chk("T1_pwrite", 32'(PWRITE), 32'(wr));
            chk("T1_paddr", 32'(PADDR), 32'(addr));
            if (wr) chk("T1_pwdata", PWDATA, wd);
            @(negedge PCLK);
            chk("T2_psel", 32'(PSEL), 32'd1);
            chk("T2_penable", 32'(PENABLE), 32'd1);
            chk("T2_pwrite", 32'(PWRITE), 32'(wr));
            @(negedge PCLK);
            chk("T3_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("T3_psel", 32'(PSEL), 32'd0);
            @(negedge PCLK);
            chk("T4_busy", 32'(busy), 32'd0);
        end else begin
            @(posedge PCLK); #1;
            req_valid[id] = 1'b0;
        end
    endtask

    initial begin
        bit got;
        exp_t e;
        int last_g;
        int gexp;

        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state; req_ready must stay low while PRESET is high.
        @(posedge PCLK); #1;
        req_valid = 2'b11;
        @(negedge PCLK);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        @(posedge PCLK); #1;
        req_valid = '0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Write, read-back, boundary address, untouched address.
        xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0);
        xfer(1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF);
        xfer(1, 1'b1, 8'hFF, 32'h12345678, 32'h0);
        xfer(1, 1'b0, 8'hFF, 32'h0,        32'h12345678);
        xfer(0, 1'b0, 8'h00, 32'h0,        32'h0);

        // Round robin from reset, both requesters held valid.
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        drive_cmd(0, 1'b0, 8'h10, 32'h0);
        drive_cmd(1, 1'b0, 8'hFF, 32'h0);
        last_g = 0;
        for (int g = 0; g < 4; g++) begin
            gexp = g % 2;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge PCLK);
                if (req_ready !== 2'b00) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL rr_timeout: no grant %0d within 20 cycles, required a grant", g);
            end else begin
                chk("rr_order", 32'(req_ready), 32'(1) << gexp);
                if (g > 0) chk("rr_spacing", 32'(cyc - last_g), 32'd4);
                last_g = cyc;
                e.id = gexp;
                e.rdata = (gexp == 0) ? 32'hDEADBEEF : 32'h12345678;
                exp_q.push_back(e);
            end
        end
        @(posedge PCLK); #1;
        req_valid = '0;
        repeat (5) @(negedge PCLK);

        // Reset during ACCESS abandons the transfer and restarts at req0.
        @(posedge PCLK); #1;
        drive_cmd(0, 1'b1, 8'h20, 32'hA5A5A5A5);
        wait_grant(0, got);
        @(posedge PCLK); #1;
        req_valid = '0;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        drive_cmd(0, 1'b0, 8'h00, 32'h0);
        drive_cmd(1, 1'b0, 8'h10, 32'h0);
        @(negedge PCLK);
        chk("mr_in_access", 32'(PENABLE), 32'd1);
        chk("mr_ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("mr_psel", 32'(PSEL), 32'd0);
        chk("mr_penable", 32'(PENABLE), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_grant_req0", 32'(req_ready), 32'b01);
        if (req_ready === 2'b01) begin
            e.id = 0;
            e.rdata = 32'h0;
            exp_q.push_back(e);
        end
        @(posedge PCLK); #1;
        req_valid[0] = 1'b0;
        wait_grant(1, got);
        if (got) begin
            e.id = 1;
            e.rdata = 32'hDEADBEEF;
            exp_q.push_back(e);
        end
        @(posedge PCLK); #1;
        req_valid = '0;
        repeat (5) @(negedge PCLK);

        // Idle stability.
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            chk("idle_outputs", {28'd0, busy, PSEL, rsp_valid, |req_ready}, 32'd0);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
